// File: rtl/sata_tx_align_pkg.sv
// Shared SATA primitive constants and dword type used by the TX and RX link-side blocks.
// Primitive words are little-endian: byte 0 carries the K28.x control character.
package sata_tx_align_pkg;

    localparam int DWORD_W = 32;
    localparam int CTRL_W  = 4;

    typedef struct packed {
        logic [DWORD_W-1:0] data;
        logic [CTRL_W-1:0]  ctrl;
    } sata_dword_t;

    localparam logic [CTRL_W-1:0]  PRIM_CTRL  = 4'b0001;
    localparam logic [DWORD_W-1:0] PRIM_ALIGN = 32'h7B4A4ABC;
    localparam logic [DWORD_W-1:0] PRIM_SYNC  = 32'hB5B5957C;
    localparam logic [DWORD_W-1:0] PRIM_CONT  = 32'h9999AA7C;
    localparam logic [DWORD_W-1:0] PRIM_HOLD  = 32'hD5D5AA7C;
    localparam logic [DWORD_W-1:0] PRIM_HOLDA = 32'h9595AA7C;
    localparam logic [DWORD_W-1:0] PRIM_X_RDY = 32'h5757B57C;
    localparam logic [DWORD_W-1:0] PRIM_R_RDY = 32'h4A4A957C;
    localparam logic [DWORD_W-1:0] PRIM_R_IP  = 32'h5555B57C;
    localparam logic [DWORD_W-1:0] PRIM_R_OK  = 32'h3535B57C;
    localparam logic [DWORD_W-1:0] PRIM_R_ERR = 32'h5656B57C;
    localparam logic [DWORD_W-1:0] PRIM_SOF   = 32'h3737B57C;
    localparam logic [DWORD_W-1:0] PRIM_EOF   = 32'hD5D5B57C;
    localparam logic [DWORD_W-1:0] PRIM_WTRM  = 32'h5858B57C;

    function automatic sata_dword_t align_dword();
        return '{data: PRIM_ALIGN, ctrl: PRIM_CTRL};
    endfunction

endpackage

// File: rtl/sata_tx_align_if.sv
// Link-layer to PHY TX dword path through the ALIGN inserter.
// Handshake: tx_readyout=1 means the dword on tx_datain/tx_ctrlin is consumed on this
// rising edge; while it is 0 the link layer holds tx_datain/tx_ctrlin unchanged.
interface sata_tx_align_if;
    import sata_tx_align_pkg::*;

    logic               tx_en;
    logic [DWORD_W-1:0] tx_datain;
    logic [CTRL_W-1:0]  tx_ctrlin;
    logic               tx_readyout;
    logic [DWORD_W-1:0] tx_dataout;
    logic [CTRL_W-1:0]  tx_ctrlout;
    logic               tx_alignout;

    modport master (
        output tx_en, tx_datain, tx_ctrlin,
        input  tx_readyout, tx_dataout, tx_ctrlout, tx_alignout
    );

    modport slave (
        input  tx_en, tx_datain, tx_ctrlin,
        output tx_readyout, tx_dataout, tx_ctrlout, tx_alignout
    );

endinterface

// File: rtl/sata_tx_align.sv
// TX ALIGN inserter: forwards link dwords with one cycle of latency, inserts an ALIGN burst
// every ALIGN_PERIOD transfers and sends continuous ALIGNs while the PHY is not enabled.
module sata_tx_align
    import sata_tx_align_pkg::*;
#(
    parameter int ALIGN_PERIOD = 256,
    parameter int ALIGN_COUNT  = 2
) (
    input  logic              tx_clkin,
    input  logic              tx_rst,
    sata_tx_align_if.slave    bus,
    output logic [1:0]        o_dbg_state
);

    localparam int PW = (ALIGN_PERIOD > 1) ? $clog2(ALIGN_PERIOD) : 1;
    localparam int AW = $clog2(ALIGN_COUNT) + 1;
    localparam logic [PW-1:0] P_LAST = PW'(ALIGN_PERIOD - 1);
    localparam logic [AW-1:0] A_LAST = AW'(ALIGN_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PASS   = 2'd1,
        S_INSERT = 2'd2
    } state_t;

    state_t      r_state, w_state_next;
    logic [PW-1:0] r_pcnt, w_pcnt_next;
    logic [AW-1:0] r_acnt, w_acnt_next;
    sata_dword_t r_out, w_out_next;
    logic        r_align, w_align_next;
    logic        w_ready;

    // Consumption happens only in PASS; a falling tx_en cancels it in the same cycle.
    assign w_ready = (r_state == S_PASS) && bus.tx_en;

    always_comb begin
        w_state_next = r_state;
        w_pcnt_next  = r_pcnt;
        w_acnt_next  = r_acnt;
        w_out_next   = align_dword();
        w_align_next = 1'b1;
        if (!bus.tx_en) begin
            w_state_next = S_IDLE;
            w_pcnt_next  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_next = S_PASS;
                    w_pcnt_next  = '0;
                end
                S_PASS: begin
                    w_out_next   = '{data: bus.tx_datain, ctrl: bus.tx_ctrlin};
                    w_align_next = 1'b0;
                    if (r_pcnt == P_LAST) begin
                        w_pcnt_next  = '0;
                        w_acnt_next  = '0;
                        w_state_next = S_INSERT;
                    end else begin
                        w_pcnt_next = r_pcnt + 1'b1;
                    end
                end
                S_INSERT: begin
                    w_acnt_next = r_acnt + 1'b1;
                    if (r_acnt == A_LAST) begin
                        w_state_next = S_PASS;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge tx_clkin) begin
        if (tx_rst) begin
            r_state <= S_IDLE;
            r_pcnt  <= '0;
            r_acnt  <= '0;
            r_out   <= align_dword();
            r_align <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_pcnt  <= w_pcnt_next;
            r_acnt  <= w_acnt_next;
            r_out   <= w_out_next;
            r_align <= w_align_next;
        end
    end

    assign bus.tx_readyout = w_ready;
    assign bus.tx_dataout  = r_out.data;
    assign bus.tx_ctrlout  = r_out.ctrl;
    assign bus.tx_alignout = r_align;
    assign o_dbg_state     = r_state;

endmodule
